cam_capture_dec: RTL

Parametrised successor to the single-purpose OV7670 pixel capture stage. It samples the camera's 8-bit DVP bus (vsync, href, d) in the pclk domain. It assembles two-byte pixels in one of three run-time formats and decimates independently in X and Y by 1/2/4/8. It emits frame-buffer writes (addr, dout, we) with address saturation, frame boundary reporting and frame/line counters. It sits between the camera pins and the frame-buffer block RAM write port.

---
 rtl/cam_capture_dec.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/cam_capture_dec.sv
// cam_capture_dec: DVP camera capture with format conversion,
// X/Y decimation and saturating frame-buffer write addressing.
module cam_capture_dec #(
  parameter int ADDR_W  = 19,
  parameter int MAX_PIX = 307200,
  parameter int FCNT_W  = 8
) (
  input  logic              pclk,
  input  logic              resetn,
  input  logic              enable,
  input  logic [1:0]        fmt,
  input  logic [1:0]        xdec,
  input  logic [1:0]        ydec,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  output logic [ADDR_W-1:0] addr,
  output logic [15:0]       dout,
  output logic              we,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic [9:0]        line_cnt,
  output logic              overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_BLANK,
    S_ACTIVE
  } state_t;

  localparam logic [ADDR_W-1:0] LP_MAX  = ADDR_W'(MAX_PIX);
  localparam logic [ADDR_W-1:0] LP_AONE = ADDR_W'(1);
  localparam logic [FCNT_W-1:0] LP_FONE = FCNT_W'(1);

  state_t r_state;
  state_t w_next;
  logic   w_done;

  logic        r_vs;
  logic        r_hr;
  logic [7:0]  r_d;
  logic        r_vs_d;
  logic        r_hr_d;
  logic        r_phase;
  logic [7:0]  r_hi;
  logic [2:0]  r_col;
  logic [2:0]  r_row;
  logic [1:0]  r_fmt;
  logic [1:0]  r_xdec;
  logic [1:0]  r_ydec;

  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_dout;
  logic              r_we;
  logic              r_done;
  logic [FCNT_W-1:0] r_fcnt;
  logic [9:0]        r_lcnt;
  logic              r_ovf;

  logic        w_vs_rise;
  logic        w_vs_fall;
  logic        w_hr_rise;
  logic        w_hr_fall;
  logic        w_pix;
  logic [15:0] w_pix16;
  logic [15:0] w_fdata;
  logic [2:0]  w_xmask;
  logic [2:0]  w_ymask;
  logic        w_keep;
  logic        w_room;
  logic        w_wr;
  logic        w_drop;

  function automatic logic [2:0] f_mask(input logic [1:0] n);
    logic [2:0] m;
    m = 3'b000;
    unique case (n)
      2'd0: m = 3'b000;
      2'd1: m = 3'b001;
      2'd2: m = 3'b011;
      2'd3: m = 3'b111;
    endcase
    return m;
  endfunction

  assign w_vs_rise = r_vs & ~r_vs_d;
  assign w_vs_fall = ~r_vs & r_vs_d;
  assign w_hr_rise = r_hr & ~r_hr_d;
  assign w_hr_fall = ~r_hr & r_hr_d;
  assign w_pix     = r_hr & r_phase;
  assign w_pix16   = {r_hi, r_d};
  assign w_xmask   = f_mask(r_xdec);
  assign w_ymask   = f_mask(r_ydec);
  assign w_room    = (r_addr < LP_MAX);

  // a vsync rise ends the frame at once, so it also kills any in-flight pixel
  assign w_keep = (r_state == S_ACTIVE) & ~w_vs_rise & w_pix
                & ((r_col & w_xmask) == 3'b000)
                & ((r_row & w_ymask) == 3'b000);
  assign w_wr   = w_keep & w_room;
  assign w_drop = w_keep & ~w_room;

  always_comb begin
    w_fdata = w_pix16;
    unique case (1'b1)
      (r_fmt == 2'b00):
        w_fdata = {4'h0, w_pix16[15:12],
                   w_pix16[10:7], w_pix16[4:1]};
      (r_fmt == 2'b10):
        w_fdata = {8'h00, r_hi};
      default:
        w_fdata = w_pix16;
    endcase
  end

  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    unique case (r_state)
      S_IDLE:   if (enable) w_next = S_ARM;
      S_ARM:    if (w_vs_rise) w_next = S_BLANK;
      S_BLANK:  if (w_vs_fall) w_next = S_ACTIVE;
      S_ACTIVE: begin
        if (w_vs_rise) begin
          w_done = 1'b1;
          w_next = enable ? S_BLANK : S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      r_vs    <= 1'b0;
      r_hr    <= 1'b0;
      r_d     <= 8'h00;
      r_vs_d  <= 1'b0;
      r_hr_d  <= 1'b0;
      r_phase <= 1'b0;
      r_hi    <= 8'h00;
    end else begin
      r_vs    <= vsync;
      r_hr    <= href;
      r_d     <= d;
      r_vs_d  <= r_vs;
      r_hr_d  <= r_hr;
      r_phase <= r_hr ? ~r_phase : 1'b0;
      if (r_hr && !r_phase) r_hi <= r_d;
    end
  end

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      r_addr <= '0;
      r_dout <= 16'h0000;
      r_we   <= 1'b0;
      r_done <= 1'b0;
      r_fcnt <= '0;
      r_lcnt <= 10'd0;
      r_ovf  <= 1'b0;
      r_col  <= 3'd0;
      r_row  <= 3'd0;
      r_fmt  <= 2'b00;
      r_xdec <= 2'd0;
      r_ydec <= 2'd0;
    end else begin
      r_we   <= w_wr;
      r_done <= w_done;
      if (w_done) r_fcnt <= r_fcnt + LP_FONE;
      if (w_wr) r_dout <= w_fdata;
      if (r_state == S_BLANK) begin
        r_addr <= '0;
        r_row  <= 3'd0;
        r_col  <= 3'd0;
        r_lcnt <= 10'd0;
        r_ovf  <= 1'b0;
        if (w_vs_fall) begin
          r_fmt  <= fmt;
          r_xdec <= xdec;
          r_ydec <= ydec;
        end
      end else begin
        if (r_we) r_addr <= r_addr + LP_AONE;
        if (w_drop) r_ovf <= 1'b1;
        if (r_state == S_ACTIVE) begin
          if (w_hr_rise) begin
            r_col <= 3'd0;
            if (r_lcnt != 10'h3FF) r_lcnt <= r_lcnt + 10'd1;
          end else if (w_pix) begin
            r_col <= r_col + 3'd1;
          end
          if (w_hr_fall) r_row <= r_row + 3'd1;
        end
      end
    end
  end

  assign addr       = r_addr;
  assign dout       = r_dout;
  assign we         = r_we;
  assign frame_done = r_done;
  assign frame_cnt  = r_fcnt;
  assign line_cnt   = r_lcnt;
  assign overflow   = r_ovf;

endmodule
